// File: rtl/seq_calculator_core.sv
// Sequential calculator core: debounced buttons, operand-entry FSM, registered ALU result
// with carry/overflow/zero flags, optional result chaining, and display value/mode outputs.
module seq_calculator_core #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 16,
    parameter bit          CHAIN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op,
    input  logic             btn_confirm,
    input  logic             btn_clear,
    input  logic             btn_mode,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             result_valid,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_dec
);

    localparam int unsigned   CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DbLast = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StEnterA = 2'b00,
        StEnterB = 2'b01,
        StExec   = 2'b10,
        StResult = 2'b11
    } state_e;

    // Button index: 0 confirm, 1 clear, 2 mode
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q, level_q, pulse_q;
    logic [CW-1:0] cnt_q [3];
    logic          confirm_p, clear_p, mode_p;

    assign btn_raw   = {btn_mode, btn_clear, btn_confirm};
    assign confirm_p = pulse_q[0];
    assign clear_p   = pulse_q[1];
    assign mode_p    = pulse_q[2];

    // Synchronise each button, accept a level change after DB_CYCLES differing samples,
    // and emit a one-cycle pulse when the accepted level rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            pulse_q <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DbLast) begin
                    cnt_q[i]   <= '0;
                    level_q[i] <= sync2_q[i];
                    pulse_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] operand_a_q, operand_a_d, operand_b_q, operand_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             flag_c_q, flag_c_d, flag_v_q, flag_v_d, flag_z_q, flag_z_d;
    logic             disp_dec_q, disp_dec_d;

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign sum_ext  = {1'b0, operand_a_q} + {1'b0, operand_b_q};
    // Top bit of the widened difference is the unsigned borrow (a < b)
    assign diff_ext = {1'b0, operand_a_q} - {1'b0, operand_b_q};

    // ALU on the latched operands and opcode
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            2'b00: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (operand_a_q[WIDTH-1] == operand_b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != operand_a_q[WIDTH-1]);
            end
            2'b01: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (operand_a_q[WIDTH-1] != operand_b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != operand_a_q[WIDTH-1]);
            end
            2'b10:   alu_res = operand_a_q & operand_b_q;
            default: alu_res = operand_a_q | operand_b_q;
        endcase
    end

    // FSM next state and datapath register updates; clear takes priority over confirm
    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        op_d        = op_q;
        result_d    = result_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        flag_z_d    = flag_z_q;
        disp_dec_d  = disp_dec_q ^ mode_p;
        if (clear_p) begin
            state_d     = StEnterA;
            operand_a_d = '0;
            operand_b_d = '0;
            op_d        = '0;
            result_d    = '0;
            flag_c_d    = 1'b0;
            flag_v_d    = 1'b0;
            flag_z_d    = 1'b0;
        end else begin
            case (state_q)
                StEnterA: begin
                    if (confirm_p) begin
                        operand_a_d = sw;
                        state_d     = StEnterB;
                    end
                end
                StEnterB: begin
                    if (confirm_p) begin
                        operand_b_d = sw;
                        op_d        = op;
                        state_d     = StExec;
                    end
                end
                StExec: begin
                    result_d = alu_res;
                    flag_c_d = alu_c;
                    flag_v_d = alu_v;
                    flag_z_d = (alu_res == '0);
                    state_d  = StResult;
                end
                StResult: begin
                    if (confirm_p) begin
                        if (CHAIN) begin
                            operand_a_d = result_q;
                            state_d     = StEnterB;
                        end else begin
                            state_d = StEnterA;
                        end
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEnterA;
            operand_a_q <= '0;
            operand_b_q <= '0;
            op_q        <= '0;
            result_q    <= '0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            disp_dec_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            flag_z_q    <= flag_z_d;
            disp_dec_q  <= disp_dec_d;
        end
    end

    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;
    assign result       = result_q;
    assign flag_c       = flag_c_q;
    assign flag_v       = flag_v_q;
    assign flag_z       = flag_z_q;
    assign state        = state_q;
    assign result_valid = (state_q == StResult);
    assign disp_value   = (state_q == StResult) ? result_q : sw;
    assign disp_dec     = disp_dec_q;

endmodule

// File: tb/tb_seq_calculator_core.sv
// Self-checking bench for seq_calculator_core: scoreboard of expected ALU results plus
// directed checks on debounce, chaining, clear priority, mode toggling and async reset.
module tb_seq_calculator_core;

    localparam int W  = 4;
    localparam int DB = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [1:0]   op;
    logic         btn_confirm, btn_clear, btn_mode;

    logic [W-1:0] operand_a, operand_b, result, disp_value;
    logic         flag_c, flag_v, flag_z, result_valid, disp_dec;
    logic [1:0]   state;

    logic [W-1:0] c0_operand_a, c0_operand_b, c0_result, c0_disp_value;
    logic         c0_flag_c, c0_flag_v, c0_flag_z, c0_result_valid, c0_disp_dec;
    logic [1:0]   c0_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {c, v, z, result} per completed calculation
    logic [W+2:0] exp_q [$];
    logic         rv_prev;

    always #5 clk = ~clk;

    seq_calculator_core #(.WIDTH(W), .DB_CYCLES(DB), .CHAIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .op(op),
        .btn_confirm(btn_confirm), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .operand_a(operand_a), .operand_b(operand_b), .result(result),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
        .result_valid(result_valid), .state(state),
        .disp_value(disp_value), .disp_dec(disp_dec)
    );

    seq_calculator_core #(.WIDTH(W), .DB_CYCLES(DB), .CHAIN(1'b0)) dut_nochain (
        .clk(clk), .rst_n(rst_n), .sw(sw), .op(op),
        .btn_confirm(btn_confirm), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .operand_a(c0_operand_a), .operand_b(c0_operand_b), .result(c0_result),
        .flag_c(c0_flag_c), .flag_v(c0_flag_v), .flag_z(c0_flag_z),
        .result_valid(c0_result_valid), .state(c0_state),
        .disp_value(c0_disp_value), .disp_dec(c0_disp_dec)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference ALU using integer arithmetic and signed range tests for overflow
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] o);
        int ua, ub, sa, sb, r, s;
        logic c, v;
        logic [W-1:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        c = 1'b0;
        v = 1'b0;
        case (o)
            2'b00: begin
                r = ua + ub; s = sa + sb;
                c = (r > (1 << W) - 1);
                v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            2'b01: begin
                r = ua - ub; s = sa - sb;
                c = (ua < ub);
                v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            2'b10:   r = ua & ub;
            default: r = ua | ub;
        endcase
        res = r[W-1:0];
        return {c, v, (res == '0), res};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 confirm, 1 clear, 2 mode; held long enough to debounce, then released
    task automatic press(input int which);
        @(negedge clk);
        case (which)
            0: btn_confirm = 1'b1;
            1: btn_clear   = 1'b1;
            default: btn_mode = 1'b1;
        endcase
        cycles(8);
        btn_confirm = 1'b0;
        btn_clear   = 1'b0;
        btn_mode    = 1'b0;
        cycles(8);
    endtask

    task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
        sw = a;
        press(0);
        sw = b;
        op = o;
        exp_q.push_back(model(a, b, o));
        press(0);
    endtask

    // Scoreboard: compare on each rising edge of result_valid
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev <= 1'b0;
        end else begin
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_extra_result", 32'(result_valid), 32'd0);
                end else begin
                    check_val("sb_flags_result", 32'({flag_c, flag_v, flag_z, result}),
                              32'(exp_q[0]));
                    check_val("sb_disp_value", 32'(disp_value), 32'(exp_q[0][W-1:0]));
                    void'(exp_q.pop_front());
                end
            end
            rv_prev <= result_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        rst_n = 1'b0;
        sw = '0;
        op = '0;
        btn_confirm = 1'b0;
        btn_clear = 1'b0;
        btn_mode = 1'b0;
        cycles(3);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_result", 32'({flag_c, flag_v, flag_z, result}), 32'd0);
        check_val("rst_operands", 32'({operand_a, operand_b}), 32'd0);
        check_val("rst_valid_dec", 32'({result_valid, disp_dec}), 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // 3 + 5: signed overflow
        calc(4'd3, 4'd5, 2'b00);
        check_val("add_state", 32'(state), 32'd3);
        check_val("add_valid", 32'(result_valid), 32'd1);
        check_val("add_disp", 32'(disp_value), 32'd8);
        check_val("add_v", 32'(flag_v), 32'd1);
        press(1);
        check_val("clr_state", 32'(state), 32'd0);
        check_val("clr_result", 32'(result), 32'd0);

        // 3 - 5: borrow; 15 + 1: carry and zero
        calc(4'd3, 4'd5, 2'b01);
        check_val("sub_result", 32'(result), 32'hE);
        press(1);
        calc(4'd15, 4'd1, 2'b00);
        check_val("wrap_z", 32'({flag_c, flag_z}), 32'b11);
        press(1);
        calc(4'd12, 4'd10, 2'b10);
        press(1);
        calc(4'd12, 4'd3, 2'b11);
        press(1);

        // Chaining: 2 + 3 = 5, then 5 + 4 = 9
        calc(4'd2, 4'd3, 2'b00);
        sw = 4'd4;
        press(0);
        check_val("chain_state", 32'(state), 32'd1);
        check_val("chain_a", 32'(operand_a), 32'd5);
        op = 2'b00;
        exp_q.push_back(model(4'd5, 4'd4, 2'b00));
        press(0);
        check_val("chain_result", 32'(result), 32'd9);
        press(1);

        // Glitch shorter than the debounce window is ignored
        sw = 4'd7;
        @(negedge clk);
        btn_confirm = 1'b1;
        @(negedge clk);
        btn_confirm = 1'b0;
        cycles(10);
        check_val("glitch_state", 32'(state), 32'd0);
        // Long hold advances exactly once
        btn_confirm = 1'b1;
        cycles(50);
        btn_confirm = 1'b0;
        cycles(10);
        check_val("hold_state", 32'(state), 32'd1);
        check_val("hold_a", 32'(operand_a), 32'd7);

        // Mode on, then clear and confirm together in ENTER_B
        press(2);
        check_val("mode_on", 32'(disp_dec), 32'd1);
        @(negedge clk);
        btn_confirm = 1'b1;
        btn_clear = 1'b1;
        cycles(8);
        btn_confirm = 1'b0;
        btn_clear = 1'b0;
        cycles(8);
        check_val("clrwin_state", 32'(state), 32'd0);
        check_val("clrwin_zero", 32'({operand_a, operand_b, result, flag_c, flag_v, flag_z}),
                  32'd0);
        check_val("clrwin_dec", 32'(disp_dec), 32'd1);

        // Asynchronous reset while in EXEC
        sw = 4'd6;
        press(0);
        sw = 4'd9;
        op = 2'b00;
        @(negedge clk);
        btn_confirm = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (state == 2'b10) found = 1'b1;
        end
        check_val("exec_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_data", 32'({operand_a, operand_b, result, flag_c, flag_v, flag_z}), 32'd0);
        check_val("arst_valid_dec", 32'({result_valid, disp_dec}), 32'd0);
        check_val("arst_disp", 32'(disp_value), 32'(sw));
        btn_confirm = 1'b0;
        cycles(5);
        rst_n = 1'b1;
        cycles(10);
        check_val("post_rst_state", 32'(state), 32'd0);
        press(2);
        check_val("mode_1", 32'(disp_dec), 32'd1);
        press(2);
        check_val("mode_0", 32'(disp_dec), 32'd0);

        // CHAIN=0 instance returns to ENTER_A from RESULT
        press(1);
        calc(4'd1, 4'd1, 2'b00);
        check_val("nc_state_res", 32'(c0_state), 32'd3);
        check_val("nc_result", 32'(c0_result), 32'd2);
        press(0);
        check_val("nc_state_back", 32'(c0_state), 32'd0);
        check_val("c1_state_back", 32'(state), 32'd1);
        check_val("c1_chain_a", 32'(operand_a), 32'd2);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
